// File: rtl/prog_mem_loader_if.sv
// Bus bundle for the TD4 program memory: mode control, serial load port and CPU port.
// master = host/CPU side, slave = memory side.
interface prog_mem_loader_if #(
  parameter int OPC_W  = 4,
  parameter int IMM_W  = 4,
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic              clear_req;
  logic              ld_valid;
  logic              ld_ready;
  logic [OPC_W-1:0]  ld_opcode;
  logic [IMM_W-1:0]  ld_imm;
  logic              ld_addr_rst;
  logic [ADDR_W-1:0] ld_ptr;
  logic              ld_full;
  logic              busy;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [OPC_W-1:0]  cpu_opcode_i;
  logic [IMM_W-1:0]  cpu_imm_i;
  logic [OPC_W-1:0]  cpu_opcode;
  logic [IMM_W-1:0]  cpu_imm;

  modport master (
    output load_en, clear_req, ld_valid, ld_opcode, ld_imm, ld_addr_rst,
    output cpu_addr, cpu_we, cpu_opcode_i, cpu_imm_i,
    input  ld_ready, ld_ptr, ld_full, busy, cpu_opcode, cpu_imm
  );

  modport slave (
    input  load_en, clear_req, ld_valid, ld_opcode, ld_imm, ld_addr_rst,
    input  cpu_addr, cpu_we, cpu_opcode_i, cpu_imm_i,
    output ld_ready, ld_ptr, ld_full, busy, cpu_opcode, cpu_imm
  );
endinterface

// File: rtl/prog_mem_loader.sv
// TD4 program memory with serial load port, CPU read/write port and a
// one-word-per-cycle clear sweep that runs out of reset and on clear_req.
module prog_mem_loader #(
  parameter int OPC_W  = 4,
  parameter int IMM_W  = 4,
  parameter int ADDR_W = 4,
  parameter int WRAP   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  prog_mem_loader_if.slave    bus
);
  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam int                WORD_W = OPC_W + IMM_W;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic              ld_full_q, ld_full_d;
  logic              busy_q, busy_d;
  logic              ld_ready_q, ld_ready_d;
  logic              accept;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] rd_word;

  assign accept = (state_q == S_LOAD) && bus.ld_valid && ld_ready_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ld_ptr_d  = ld_ptr_q;
    ld_full_d = ld_full_q;
    case (state_q)
      S_CLEAR: begin
        // clear_req is deliberately not looked at here: a sweep never restarts
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST) state_d = bus.load_en ? S_LOAD : S_RUN;
      end
      S_RUN: begin
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end else if (bus.load_en) begin
          state_d   = S_LOAD;
          ld_ptr_d  = '0;
          ld_full_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.ld_addr_rst) begin
          ld_ptr_d  = '0;
          ld_full_d = 1'b0;
        end else if (accept) begin
          if (ld_ptr_q == LAST) begin
            if (WRAP != 0) ld_ptr_d  = '0;
            else           ld_full_d = 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + ADDR_W'(1);
          end
        end
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end else if (!bus.load_en) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    busy_d     = (state_d == S_CLEAR);
    ld_ready_d = (state_d == S_LOAD) && !ld_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_ptr_q  <= '0;
      ld_ptr_q   <= '0;
      ld_full_q  <= 1'b0;
      busy_q     <= 1'b1;
      ld_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ld_ptr_q   <= ld_ptr_d;
      ld_full_q  <= ld_full_d;
      busy_q     <= busy_d;
      ld_ready_q <= ld_ready_d;
    end
  end

  // One write port shared by sweep, loader and CPU; the state decides the owner.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.cpu_addr;
    mem_wdata = {bus.cpu_imm_i, bus.cpu_opcode_i};
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
      end
      S_LOAD: begin
        mem_we    = accept && !bus.ld_addr_rst;
        mem_waddr = ld_ptr_q;
        mem_wdata = {bus.ld_imm, bus.ld_opcode};
      end
      S_RUN:   mem_we = bus.cpu_we;
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_word = mem_q[bus.cpu_addr];
  assign {bus.cpu_imm, bus.cpu_opcode} = (state_q == S_RUN) ? rd_word : '0;

  assign bus.busy     = busy_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_ptr   = ld_ptr_q;
  assign bus.ld_full  = ld_full_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Lockstep bench for prog_mem_loader: one saturating (WRAP=0) and one wrapping (WRAP=1)
// instance share stimulus; a behavioural model feeds a scoreboard of expected outputs.
module tb_prog_mem_loader;
  localparam int M_CLEAR = 0;
  localparam int M_RUN   = 1;
  localparam int M_LOAD  = 2;

  logic       clk;
  logic       rst_n;
  logic       load_en, clear_req, ld_valid, ld_addr_rst, cpu_we;
  logic [3:0] ld_opcode, ld_imm, cpu_addr, cpu_op_i, cpu_imm_i;

  prog_mem_loader_if #(.OPC_W(4), .IMM_W(4), .ADDR_W(4)) if0 ();
  prog_mem_loader_if #(.OPC_W(4), .IMM_W(4), .ADDR_W(4)) if1 ();

  assign if0.load_en = load_en;      assign if1.load_en = load_en;
  assign if0.clear_req = clear_req;  assign if1.clear_req = clear_req;
  assign if0.ld_valid = ld_valid;    assign if1.ld_valid = ld_valid;
  assign if0.ld_opcode = ld_opcode;  assign if1.ld_opcode = ld_opcode;
  assign if0.ld_imm = ld_imm;        assign if1.ld_imm = ld_imm;
  assign if0.ld_addr_rst = ld_addr_rst; assign if1.ld_addr_rst = ld_addr_rst;
  assign if0.cpu_addr = cpu_addr;    assign if1.cpu_addr = cpu_addr;
  assign if0.cpu_we = cpu_we;        assign if1.cpu_we = cpu_we;
  assign if0.cpu_opcode_i = cpu_op_i; assign if1.cpu_opcode_i = cpu_op_i;
  assign if0.cpu_imm_i = cpu_imm_i;  assign if1.cpu_imm_i = cpu_imm_i;

  prog_mem_loader #(.OPC_W(4), .IMM_W(4), .ADDR_W(4), .WRAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  prog_mem_loader #(.OPC_W(4), .IMM_W(4), .ADDR_W(4), .WRAP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int         ms[2];
  int         mclr[2];
  int         mptr[2];
  bit         mfull[2];
  logic [7:0] mm[2][16];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_cmp(logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      e.tag = "sb_underflow";
      e.val = ~got;
    end else begin
      e = sb_q.pop_front();
    end
    chk(e.tag, got, e.val);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ms[d] = M_CLEAR; mclr[d] = 0; mptr[d] = 0; mfull[d] = 1'b0;
    end
  endtask

  // Advance the model with the inputs about to be sampled, then cross the edge.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      case (ms[d])
        M_CLEAR: begin
          mm[d][mclr[d]] = 8'h00;
          if (mclr[d] == 15) begin
            mclr[d] = 0;
            ms[d] = load_en ? M_LOAD : M_RUN;
          end else begin
            mclr[d]++;
          end
        end
        M_RUN: begin
          if (cpu_we) mm[d][cpu_addr] = {cpu_imm_i, cpu_op_i};
          if (clear_req) begin
            ms[d] = M_CLEAR; mclr[d] = 0;
          end else if (load_en) begin
            ms[d] = M_LOAD; mptr[d] = 0; mfull[d] = 1'b0;
          end
        end
        default: begin
          if (ld_addr_rst) begin
            mptr[d] = 0; mfull[d] = 1'b0;
          end else if (ld_valid && !mfull[d]) begin
            mm[d][mptr[d]] = {ld_imm, ld_opcode};
            if (mptr[d] == 15) begin
              if (d == 1) mptr[d] = 0;
              else        mfull[d] = 1'b1;
            end else begin
              mptr[d]++;
            end
          end
          if (clear_req) begin
            ms[d] = M_CLEAR; mclr[d] = 0;
          end else if (!load_en) begin
            ms[d] = M_RUN;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag);
    for (int d = 0; d < 2; d++) begin
      sb_push($sformatf("%s_busy%0d", tag, d), 32'(ms[d] == M_CLEAR));
      sb_push($sformatf("%s_ready%0d", tag, d), 32'(ms[d] == M_LOAD && !mfull[d]));
      sb_push($sformatf("%s_ptr%0d", tag, d), 32'(mptr[d]));
      sb_push($sformatf("%s_full%0d", tag, d), 32'(mfull[d]));
      sb_push($sformatf("%s_cpu%0d", tag, d), (ms[d] == M_RUN) ? 32'(mm[d][cpu_addr]) : 32'd0);
    end
    sb_cmp(32'(if0.busy)); sb_cmp(32'(if0.ld_ready)); sb_cmp(32'(if0.ld_ptr));
    sb_cmp(32'(if0.ld_full)); sb_cmp(32'({if0.cpu_imm, if0.cpu_opcode}));
    sb_cmp(32'(if1.busy)); sb_cmp(32'(if1.ld_ready)); sb_cmp(32'(if1.ld_ptr));
    sb_cmp(32'(if1.ld_full)); sb_cmp(32'({if1.cpu_imm, if1.cpu_opcode}));
  endtask

  task automatic rd_all(string tag);
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #2;
      for (int d = 0; d < 2; d++)
        sb_push($sformatf("%s_rd%0d_%0d", tag, a, d), (ms[d] == M_RUN) ? 32'(mm[d][a]) : 32'd0);
      sb_cmp(32'({if0.cpu_imm, if0.cpu_opcode}));
      sb_cmp(32'({if1.cpu_imm, if1.cpu_opcode}));
      tick();
    end
  endtask

  task automatic wait_sweep(string tag, int pulse_at);
    int n;
    n = 0;
    do begin
      clear_req = (n == pulse_at);
      tick();
      n++;
      clear_req = 1'b0;
      check_all($sformatf("%s_c%0d", tag, n));
    end while (if0.busy && n < 40);
    chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
  endtask

  task automatic load_words(int cnt, int base);
    ld_valid = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      ld_imm    = 4'(base + k + 1);
      ld_opcode = 4'(k);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; load_en = 1'b0; clear_req = 1'b0; ld_valid = 1'b0;
    ld_opcode = '0; ld_imm = '0; ld_addr_rst = 1'b0; cpu_addr = '0;
    cpu_we = 1'b0; cpu_op_i = '0; cpu_imm_i = '0;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) mm[d][a] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: power-up sweep, then everything reads zero
    wait_sweep("t1", -1);
    rd_all("t1");

    // T2/T3: stream 16 words {imm=1,op=k}, then a 17th word 8'hAB
    load_en = 1'b1;
    tick();
    check_all("t2_enter");
    ld_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ld_imm = 4'h1; ld_opcode = 4'(k);
      tick();
    end
    check_all("t2_full");
    ld_imm = 4'hA; ld_opcode = 4'hB;
    tick();
    ld_valid = 1'b0;
    check_all("t3_17th");
    load_en = 1'b0;
    tick();
    cpu_addr = 4'd5;
    #2 check_all("t2_rd5");
    chk("t2_rd5_word", 32'({if0.cpu_imm, if0.cpu_opcode}), 32'h15);
    cpu_addr = 4'd0;
    #2 check_all("t3_rd0");
    chk("t3_rd0_word", 32'({if1.cpu_imm, if1.cpu_opcode}), 32'hAB);

    // T4: CPU write in RUN lands at the edge; in LOAD it is ignored
    cpu_addr = 4'd3; cpu_we = 1'b1; cpu_imm_i = 4'h7; cpu_op_i = 4'hC;
    #2 check_all("t4_pre");
    tick();
    cpu_we = 1'b0;
    check_all("t4_post");
    chk("t4_rd7C", 32'({if0.cpu_imm, if0.cpu_opcode}), 32'h7C);
    load_en = 1'b1;
    tick();
    cpu_we = 1'b1; cpu_imm_i = 4'h5; cpu_op_i = 4'h5;
    tick();
    check_all("t4_load_cpu");
    cpu_we = 1'b0; load_en = 1'b0;
    tick();
    check_all("t4_load_we");

    // ld_addr_rst wins over a same-cycle accept and drops that word
    load_en = 1'b1;
    tick();
    load_words(6, 8);
    check_all("t5_six");
    ld_valid = 1'b1; ld_addr_rst = 1'b1; ld_imm = 4'hE; ld_opcode = 4'hE;
    tick();
    ld_valid = 1'b0; ld_addr_rst = 1'b0;
    check_all("t5_ptr_rst");
    load_words(2, 3);
    load_en = 1'b0;
    tick();
    rd_all("t5_pre");

    // T5: clear after 6 words; a clear_req inside the sweep must not restart it
    load_en = 1'b1;
    tick();
    load_words(6, 0);
    clear_req = 1'b1; load_en = 1'b0;
    tick();
    clear_req = 1'b0;
    check_all("t5_clr");
    wait_sweep("t5", 4);
    rd_all("t5");

    // T6: asynchronous reset in the middle of a load
    load_en = 1'b1;
    tick();
    load_words(9, 4);
    #2 check_all("t6_pre");
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("t6_async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; load_en = 1'b0;
    wait_sweep("t6", -1);
    rd_all("t6");

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
